// File: rtl/line_merge_buffer.sv
// One-entry write-combining buffer: merges byte-enabled stores into a single
// line image and drains it on line change, flush, full coverage or idle timeout.
module line_merge_buffer #(
  parameter int LINE_BYTES      = 16,
  parameter int WORD_BYTES      = 2,
  parameter int ADDR_W          = 16,
  parameter int IDLE_TIMEOUT    = 8,
  parameter int AUTO_FULL_DRAIN = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADDR_W-1:0]       in_addr,
  input  logic [WORD_BYTES*8-1:0] in_data,
  input  logic [WORD_BYTES-1:0]   in_be,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ADDR_W-1:0]       out_addr,
  output logic [LINE_BYTES*8-1:0] out_data,
  output logic [LINE_BYTES-1:0]   out_mask,
  output logic                    clip_pulse,
  output logic                    busy
);

  localparam int OFF   = $clog2(LINE_BYTES);
  localparam int TAG_W = ADDR_W - OFF;
  localparam int POS_W = OFF + 1;
  localparam int CNT_W = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {EMPTY, MERGE, DRAIN} state_t;

  state_t                  state, state_nxt;
  logic [LINE_BYTES*8-1:0] line_data, data_nxt;
  logic [LINE_BYTES-1:0]   line_mask, mask_nxt;
  logic [TAG_W-1:0]        line_tag, tag_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt, cnt_inc;
  logic                    clip_q, clip_nxt;

  logic [TAG_W-1:0]        in_tag;
  logic [OFF-1:0]          in_off;
  logic [POS_W-1:0]        pos;
  logic [LINE_BYTES*8-1:0] merged_data;
  logic [LINE_BYTES-1:0]   merged_mask;
  logic                    clip_any;
  logic                    merged_full;

  assign in_tag  = in_addr[ADDR_W-1:OFF];
  assign in_off  = in_addr[OFF-1:0];
  assign cnt_inc = cnt + CNT_W'(1);

  // Store image merged over the current line (a fresh zero line when EMPTY).
  // Bytes landing past the line end are dropped and only flagged.
  always_comb begin
    merged_data = (state == EMPTY) ? '0 : line_data;
    merged_mask = (state == EMPTY) ? '0 : line_mask;
    clip_any    = 1'b0;
    pos         = '0;
    for (int k = 0; k < WORD_BYTES; k++) begin
      pos = {1'b0, in_off} + POS_W'(k);
      if (in_be[k]) begin
        if (pos[OFF]) begin
          clip_any = 1'b1;
        end else begin
          merged_data[8*pos[OFF-1:0] +: 8] = in_data[8*k +: 8];
          merged_mask[pos[OFF-1:0]]        = 1'b1;
        end
      end
    end
    merged_full = (AUTO_FULL_DRAIN != 0) && (&merged_mask);
  end

  always_comb begin
    state_nxt = state;
    data_nxt  = line_data;
    mask_nxt  = line_mask;
    tag_nxt   = line_tag;
    cnt_nxt   = cnt;
    clip_nxt  = 1'b0;
    in_ready  = 1'b0;
    case (state)
      EMPTY: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_nxt  = merged_data;
          mask_nxt  = merged_mask;
          tag_nxt   = in_tag;
          cnt_nxt   = '0;
          clip_nxt  = clip_any;
          state_nxt = merged_full ? DRAIN : MERGE;
        end
      end
      MERGE: begin
        // A different-tag store is held off until the current line has left.
        in_ready = (in_tag == line_tag);
        if (in_valid && in_ready) begin
          data_nxt = merged_data;
          mask_nxt = merged_mask;
          cnt_nxt  = '0;
          clip_nxt = clip_any;
          if (flush || merged_full) state_nxt = DRAIN;
        end else if (in_valid || flush) begin
          state_nxt = DRAIN;
        end else if (IDLE_TIMEOUT != 0) begin
          cnt_nxt = cnt_inc;
          if (cnt_inc == CNT_W'(IDLE_TIMEOUT)) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          data_nxt  = '0;
          mask_nxt  = '0;
          tag_nxt   = '0;
          cnt_nxt   = '0;
          state_nxt = EMPTY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= EMPTY;
      line_data <= '0;
      line_mask <= '0;
      line_tag  <= '0;
      cnt       <= '0;
      clip_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      line_data <= data_nxt;
      line_mask <= mask_nxt;
      line_tag  <= tag_nxt;
      cnt       <= cnt_nxt;
      clip_q    <= clip_nxt;
    end
  end

  assign out_valid  = (state == DRAIN);
  assign out_addr   = {line_tag, {OFF{1'b0}}};
  assign out_data   = line_data;
  assign out_mask   = line_mask;
  assign clip_pulse = clip_q;
  assign busy       = (state != EMPTY);

endmodule
